fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter, issues word-aligned requests to instruction memory over a valid/ready handshake, and buffers returned words in a small in-order queue. It presents each {instr, pc} pair to the decoder with valid/ready. Branch and jump redirects from execute flush the queue and discard stale in-flight responses.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: NOP, opcodes, PC-select encodings,
// fetch FSM states and the instruction queue entry layout.
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        PC_SEL_NEXT   = 2'h0,
        PC_SEL_BRANCH = 2'h1
    } pc_sel_t;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push and pop may happen in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_q != '0);

    // NOTE: every variable written here gets its value on all paths, so no latch is inferred.
    always_comb begin
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned memory requests and
// queues returned words for the decoder, dropping responses made stale by redirects.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 2;

    fetch_state_t  state_q, state_d;
    pc_sel_t       pc_sel;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] iq_count, tq_count;
    logic [SW-1:0] outstanding;
    logic [31:0]   tag_pc;
    iq_entry_t     iq_wdata, iq_head;
    logic          req_fire, rsp_keep, rsp_drop, pop_fire;

    // Queued words, live requests and to-be-dropped responses share one DEPTH budget.
    assign outstanding    = SW'(iq_count) + SW'(inflight_q) + SW'(drop_cnt_q);
    assign imem_req_valid = !reset && !redirect_valid && (outstanding < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = (iq_count != '0);
    assign pop_fire    = instr_valid && instr_ready;
    assign instr       = instr_valid ? iq_head.instr : NOP;
    assign instr_pc    = instr_valid ? iq_head.pc : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (drop_cnt_d != '0) ? FLUSH : FETCH;
    end

    always_comb begin
        rsp_keep = 1'b0;
        rsp_drop = 1'b0;
        case (state_q)
            FETCH:   rsp_keep = imem_rsp_valid;
            FLUSH:   rsp_drop = imem_rsp_valid;
            default: ;
        endcase
    end

    always_comb begin
        pc_sel     = redirect_valid ? PC_SEL_BRANCH : PC_SEL_NEXT;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        case (pc_sel)
            PC_SEL_BRANCH: begin
                // A response landing in the redirect cycle is already discarded by the flush.
                fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
                inflight_d = '0;
                drop_cnt_d = drop_cnt_q + inflight_q - CW'(imem_rsp_valid);
            end
            default: begin
                if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
                inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_keep);
                drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (req_fire),
        .wdata (fetch_pc_q),
        .pop   (rsp_keep),
        .rdata (tag_pc),
        .count (tq_count)
    );

    assign iq_wdata = '{instr: imem_rsp_data, pc: tag_pc};

    fetch_fifo #(.WIDTH($bits(iq_entry_t)), .DEPTH(DEPTH)) u_instr_q (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (rsp_keep),
        .wdata (iq_wdata),
        .pop   (pop_fire),
        .rdata (iq_head),
        .count (iq_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        rsp_keep |-> (iq_count < CW'(DEPTH)));
    a_tag_present: assert property (@(posedge clk) disable iff (reset)
        rsp_keep |-> (tq_count != '0));

endmodule
